alu_dispatch_sched: RTL

- Sits between decode/rename and the 3-station ALU reservation block.
- Buffers renamed ALU instructions in a small in-order FIFO.
- Picks a free ALU station round-robin and drives exactly one allocator enable (en0/en1/en2) per cycle, with a shared registered payload.
- Tracks per-station occupancy, including the 2-cycle gap before the station's own busy/next_busy flags reflect a new issue, so no station is double-allocated.

---
 rtl/alu_dispatch_sched_if.sv | 53 +++++
 rtl/alu_dispatch_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch_sched_if.sv
// Decode-to-ALU dispatch bus: instruction offer/accept handshake, station busy flags,
// allocate enables and the shared registered payload.
interface alu_dispatch_sched_if #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int OP_W    = 6,
  parameter int TAG_W   = 4,
  parameter int RADDR_W = 5
);
  logic               in_vld;
  logic               in_rdy;
  logic [ADDR_W-1:0]  in_pc;
  logic [OP_W-1:0]    in_op;
  logic [TAG_W-1:0]   in_tagx;
  logic [TAG_W-1:0]   in_tagy;
  logic [TAG_W-1:0]   in_tagw;
  logic [WORD_W-1:0]  in_datax;
  logic [WORD_W-1:0]  in_datay;
  logic [RADDR_W-1:0] in_addrw;

  logic               alu_busy0;
  logic               alu_busy1;
  logic               alu_busy2;
  logic               next_busy0;
  logic               next_busy1;
  logic               next_busy2;

  logic               en0;
  logic               en1;
  logic               en2;
  logic [ADDR_W-1:0]  out_pc;
  logic [OP_W-1:0]    out_op;
  logic [TAG_W-1:0]   out_tagx;
  logic [TAG_W-1:0]   out_tagy;
  logic [TAG_W-1:0]   out_tagw;
  logic [WORD_W-1:0]  out_datax;
  logic [WORD_W-1:0]  out_datay;
  logic [RADDR_W-1:0] out_addrw;

  modport master (
    output in_vld, in_pc, in_op, in_tagx, in_tagy, in_tagw, in_datax, in_datay, in_addrw,
    output alu_busy0, alu_busy1, alu_busy2, next_busy0, next_busy1, next_busy2,
    input  in_rdy, en0, en1, en2,
    input  out_pc, out_op, out_tagx, out_tagy, out_tagw, out_datax, out_datay, out_addrw
  );

  modport slave (
    input  in_vld, in_pc, in_op, in_tagx, in_tagy, in_tagw, in_datax, in_datay, in_addrw,
    input  alu_busy0, alu_busy1, alu_busy2, next_busy0, next_busy1, next_busy2,
    output in_rdy, en0, en1, en2,
    output out_pc, out_op, out_tagx, out_tagy, out_tagw, out_datax, out_datay, out_addrw
  );
endinterface

// File: rtl/alu_dispatch_sched.sv
// In-order FIFO feeding 3 ALU stations round-robin; dispatch no earlier than 1 edge after push.
// Backpressure: in_rdy drops when full, in reset or when rdy=0; a stalled head waits for a free station.
module alu_dispatch_sched #(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 32,
  parameter int WORD_W       = 32,
  parameter int OP_W         = 6,
  parameter int TAG_W        = 4,
  parameter int RADDR_W      = 5,
  parameter int TAG_UNLOCKED = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rdy,
  input  logic                    i_flush,
  alu_dispatch_sched_if.slave     io_bus,
  output logic [$clog2(DEPTH):0]  o_fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [OP_W-1:0]    op;
    logic [TAG_W-1:0]   tagx;
    logic [TAG_W-1:0]   tagy;
    logic [TAG_W-1:0]   tagw;
    logic [WORD_W-1:0]  datax;
    logic [WORD_W-1:0]  datay;
    logic [RADDR_W-1:0] addrw;
  } entry_t;

  localparam entry_t PAY_RST = '{
    pc:    '0,
    op:    '0,
    tagx:  TAG_W'(TAG_UNLOCKED),
    tagy:  TAG_W'(TAG_UNLOCKED),
    tagw:  TAG_W'(TAG_UNLOCKED),
    datax: '0,
    datay: '0,
    addrw: '0
  };

  entry_t               r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [1:0]           r_rr_ptr;
  logic [2:0][1:0]      r_cool;
  logic [2:0]           r_en;
  entry_t               r_pay;

  logic                 w_in_rdy;
  logic                 w_push;
  logic                 w_pop;
  logic [2:0]           w_busy;
  logic [2:0]           w_nbusy;
  logic [2:0]           w_free;
  logic                 w_pick_vld;
  logic [1:0]           w_pick_idx;
  logic [1:0]           w_rr_nxt;
  entry_t               w_in_entry;
  entry_t               w_head;

  assign w_in_entry = '{
    pc:    io_bus.in_pc,
    op:    io_bus.in_op,
    tagx:  io_bus.in_tagx,
    tagy:  io_bus.in_tagy,
    tagw:  io_bus.in_tagw,
    datax: io_bus.in_datax,
    datay: io_bus.in_datay,
    addrw: io_bus.in_addrw
  };

  assign w_head   = r_mem[r_rd_ptr];
  assign w_busy   = {io_bus.alu_busy2, io_bus.alu_busy1, io_bus.alu_busy0};
  assign w_nbusy  = {io_bus.next_busy2, io_bus.next_busy1, io_bus.next_busy0};

  assign w_in_rdy = i_rdy && i_rst_n && (r_count < CNT_W'(DEPTH));
  assign w_push   = io_bus.in_vld && w_in_rdy && !i_flush;

  // A station's own busy flags lag an issue by 2 cycles; the cooldown covers that gap.
  always_comb begin
    w_free = '0;
    for (int k = 0; k < 3; k++) begin
      w_free[k] = !w_busy[k] && !w_nbusy[k] && (r_cool[k] == 2'd0);
    end
  end

  always_comb begin
    w_pick_vld = |w_free;
    w_pick_idx = 2'd0;
    case (r_rr_ptr)
      2'd1: begin
        if (w_free[1])      w_pick_idx = 2'd1;
        else if (w_free[2]) w_pick_idx = 2'd2;
        else                w_pick_idx = 2'd0;
      end
      2'd2: begin
        if (w_free[2])      w_pick_idx = 2'd2;
        else if (w_free[0]) w_pick_idx = 2'd0;
        else                w_pick_idx = 2'd1;
      end
      default: begin
        if (w_free[0])      w_pick_idx = 2'd0;
        else if (w_free[1]) w_pick_idx = 2'd1;
        else                w_pick_idx = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_rr_nxt = 2'd0;
    case (w_pick_idx)
      2'd0:    w_rr_nxt = 2'd1;
      2'd1:    w_rr_nxt = 2'd2;
      default: w_rr_nxt = 2'd0;
    endcase
  end

  assign w_pop = i_rdy && !i_flush && (r_count != '0) && w_pick_vld;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= 2'd0;
      r_cool   <= '0;
      r_en     <= '0;
      r_pay    <= PAY_RST;
    end else if (i_rdy) begin
      r_en <= '0;
      for (int k = 0; k < 3; k++) begin
        if (w_pop && (w_pick_idx == 2'(k))) begin
          r_cool[k] <= 2'd2;
        end else if (r_cool[k] != 2'd0) begin
          r_cool[k] <= r_cool[k] - 2'd1;
        end
      end
      // Flush keeps cooldowns and rr_ptr: already-allocated stations stay occupied.
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr         <= r_rd_ptr + PTR_W'(1);
          r_en[w_pick_idx] <= 1'b1;
          r_pay            <= w_head;
          r_rr_ptr         <= w_rr_nxt;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end else begin
      r_en <= '0;
    end
  end

  // Gating by rdy silences a pulse already registered when the pipeline freezes.
  assign io_bus.en0      = r_en[0] && i_rdy;
  assign io_bus.en1      = r_en[1] && i_rdy;
  assign io_bus.en2      = r_en[2] && i_rdy;
  assign io_bus.in_rdy   = w_in_rdy;
  assign io_bus.out_pc    = r_pay.pc;
  assign io_bus.out_op    = r_pay.op;
  assign io_bus.out_tagx  = r_pay.tagx;
  assign io_bus.out_tagy  = r_pay.tagy;
  assign io_bus.out_tagw  = r_pay.tagw;
  assign io_bus.out_datax = r_pay.datax;
  assign io_bus.out_datay = r_pay.datay;
  assign io_bus.out_addrw = r_pay.addrw;
  assign o_fifo_count     = r_count;
endmodule
